pipeline_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the load enables of PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus NOP-injection flushes.
- Resolves load-use hazards, branch-taken redirects (branch resolved from EX/MEM eq/op outputs) and multi-cycle data-memory waits with timeout.
- Provides a debug halt handshake and saturating stall/flush performance counters.

---
 rtl/pipeline_ctrl_pkg.sv | 15 +
 rtl/sat_counter.sv | 25 ++
 rtl/pipeline_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared opcode constants and controller state encoding for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_NOP = 6'h00;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; used for performance statistics.
module sat_counter
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory freeze with timeout, branch redirect,
// load-use bubble, debug halt handshake and saturating stall/flush counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_W   = 6,
    parameter int OP_W    = 6,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] ex_dest,
    input  logic [OP_W-1:0]  ex_op,
    input  logic [OP_W-1:0]  mem_op,
    input  logic             mem_eq,
    input  logic             mem_ready,
    input  logic             halt_req,
    output logic             pc_load,
    output logic             if_id_load,
    output logic             id_ex_load,
    output logic             ex_mem_load,
    output logic             mem_wb_load,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             pc_sel_target,
    output logic             halt_ack,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    state_t         r_state;
    logic [WCW-1:0] r_wait_cnt;
    logic           r_mem_err;
    logic           r_halt_ack;

    logic w_mem_access;
    logic w_timeout_hit;
    logic w_freeze;
    logic w_branch;
    logic w_load_use;
    logic w_flush_inc;
    logic w_stall_inc;

    assign w_mem_access  = (mem_op == OP_W'(OP_LW)) || (mem_op == OP_W'(OP_SW));
    assign w_timeout_hit = (r_state == MEM_WAIT) && (r_wait_cnt == WAIT_LAST) && !mem_ready;
    assign w_freeze      = (r_state != HALTED) && w_mem_access && !mem_ready && !w_timeout_hit;
    assign w_branch      = (mem_op == OP_W'(OP_BEQ)) && mem_eq;
    assign w_load_use    = (ex_op == OP_W'(OP_LW)) && id_valid && (ex_dest != '0) &&
                           ((ex_dest == id_rs) || (ex_dest == id_rt));

    // Load/flush decode; everything is held at zero while reset is asserted.
    always_comb begin
        pc_load       = 1'b0;
        if_id_load    = 1'b0;
        id_ex_load    = 1'b0;
        ex_mem_load   = 1'b0;
        mem_wb_load   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        pc_sel_target = 1'b0;
        w_flush_inc   = 1'b0;
        if (reset && (r_state != HALTED) && !w_freeze) begin
            id_ex_load  = 1'b1;
            ex_mem_load = 1'b1;
            mem_wb_load = 1'b1;
            if (w_branch) begin
                pc_load       = 1'b1;
                if_id_load    = 1'b1;
                if_id_flush   = 1'b1;
                id_ex_flush   = 1'b1;
                ex_mem_flush  = 1'b1;
                pc_sel_target = 1'b1;
                w_flush_inc   = 1'b1;
            end else if (w_load_use) begin
                id_ex_flush = 1'b1;
            end else begin
                pc_load    = 1'b1;
                if_id_load = 1'b1;
            end
        end
    end

    assign w_stall_inc = !pc_load && (r_state != HALTED) && reset;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
            r_halt_ack <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_freeze) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= r_wait_cnt + WCW'(1);
                    end else if (halt_req) begin
                        r_state    <= HALTED;
                        r_halt_ack <= 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (w_freeze) begin
                        r_wait_cnt <= r_wait_cnt + WCW'(1);
                    end else begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                        if (w_timeout_hit) begin
                            r_mem_err <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    if (!halt_req) begin
                        r_state    <= RUN;
                        r_halt_ack <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= RUN;
                    r_wait_cnt <= '0;
                    r_halt_ack <= 1'b0;
                end
            endcase
        end
    end

    assign mem_err  = r_mem_err;
    assign halt_ack = r_halt_ack;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (w_flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with TIMEOUT=4 and 4-bit counters to reach timeout and saturation.
`timescale 1ns/1ps
module tb_pipeline_ctrl;

    localparam int REG_W = 6;
    localparam int OP_W  = 6;
    localparam int CNT_W = 4;

    // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_fl, id_ex_fl, ex_mem_fl, pc_sel}
    localparam logic [8:0] O_FROZEN = 9'b00000_000_0;
    localparam logic [8:0] O_NORMAL = 9'b11111_000_0;
    localparam logic [8:0] O_BRANCH = 9'b11111_111_1;
    localparam logic [8:0] O_LDUSE  = 9'b00111_010_0;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             id_valid;
    logic [REG_W-1:0] id_rs, id_rt, ex_dest;
    logic [OP_W-1:0]  ex_op, mem_op;
    logic             mem_eq, mem_ready, halt_req;
    logic             pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic             if_id_flush, id_ex_flush, ex_mem_flush, pc_sel_target;
    logic             halt_ack, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [8:0]       outs;

    int n_vec = 0;
    int n_err = 0;

    pipeline_ctrl #(.REG_W(REG_W), .OP_W(OP_W), .TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .ex_dest(ex_dest), .ex_op(ex_op), .mem_op(mem_op), .mem_eq(mem_eq),
        .mem_ready(mem_ready), .halt_req(halt_req), .pc_load(pc_load),
        .if_id_load(if_id_load), .id_ex_load(id_ex_load), .ex_mem_load(ex_mem_load),
        .mem_wb_load(mem_wb_load), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .pc_sel_target(pc_sel_target), .halt_ack(halt_ack),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign outs = {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                   if_id_flush, id_ex_flush, ex_mem_flush, pc_sel_target};

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; ex_dest = 0; ex_op = 0;
        mem_op = 0; mem_eq = 0; mem_ready = 0; halt_req = 0;
    endtask

    task automatic set_load_use();
        ex_op = 6'h23; ex_dest = 6'd5; id_rs = 6'd5; id_rt = 6'd9; id_valid = 1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 0;
        tick();
        tick();
        reset = 1;
    endtask

    task automatic test_reset();
        set_load_use();
        mem_op = 6'h04; mem_eq = 1;
        #2;
        n_vec++; if (outs !== O_FROZEN) begin n_err++; $display("FAIL reset_outs: got %b want %b", outs, O_FROZEN); end
        n_vec++; if (stall_cnt !== 0 || flush_cnt !== 0) begin n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
        n_vec++; if (mem_err !== 0 || halt_ack !== 0) begin n_err++; $display("FAIL reset_flags: got err=%b ack=%b want 0/0", mem_err, halt_ack); end
        do_reset();
        #2;
        n_vec++; if (outs !== O_NORMAL) begin n_err++; $display("FAIL reset_release: got %b want %b", outs, O_NORMAL); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use();
        #2;
        n_vec++; if (outs !== O_LDUSE) begin n_err++; $display("FAIL lu_rs: got %b want %b", outs, O_LDUSE); end
        tick();
        n_vec++; if (stall_cnt !== 1) begin n_err++; $display("FAIL lu_stall1: got %0d want 1", stall_cnt); end
        idle();
        #2;
        n_vec++; if (outs !== O_NORMAL) begin n_err++; $display("FAIL lu_after: got %b want %b", outs, O_NORMAL); end
        tick();
        ex_op = 6'h23; ex_dest = 6'd7; id_rs = 6'd3; id_rt = 6'd7; id_valid = 1;
        #2;
        n_vec++; if (outs !== O_LDUSE) begin n_err++; $display("FAIL lu_rt: got %b want %b", outs, O_LDUSE); end
        tick();
        n_vec++; if (stall_cnt !== 2) begin n_err++; $display("FAIL lu_stall2: got %0d want 2", stall_cnt); end
        ex_dest = 6'd0; id_rs = 6'd0; id_rt = 6'd0;
        #2;
        n_vec++; if (outs !== O_NORMAL) begin n_err++; $display("FAIL lu_r0: got %b want %b", outs, O_NORMAL); end
        tick();
        ex_dest = 6'd5; id_rs = 6'd5; id_valid = 0;
        #2;
        n_vec++; if (outs !== O_NORMAL) begin n_err++; $display("FAIL lu_invalid: got %b want %b", outs, O_NORMAL); end
        ex_op = 6'h2B; id_valid = 1;
        #1;
        n_vec++; if (outs !== O_NORMAL) begin n_err++; $display("FAIL lu_notlw: got %b want %b", outs, O_NORMAL); end
        tick();
        n_vec++; if (stall_cnt !== 2) begin n_err++; $display("FAIL lu_stall_hold: got %0d want 2", stall_cnt); end
    endtask

    task automatic test_branch();
        do_reset();
        set_load_use();
        mem_op = 6'h04; mem_eq = 1;
        #2;
        n_vec++; if (outs !== O_BRANCH) begin n_err++; $display("FAIL br_taken: got %b want %b", outs, O_BRANCH); end
        tick();
        n_vec++; if (flush_cnt !== 1 || stall_cnt !== 0) begin n_err++; $display("FAIL br_cnt: got flush=%0d stall=%0d want 1/0", flush_cnt, stall_cnt); end
        mem_eq = 0;
        #2;
        n_vec++; if (outs !== O_LDUSE) begin n_err++; $display("FAIL br_not_taken: got %b want %b", outs, O_LDUSE); end
        tick();
        n_vec++; if (flush_cnt !== 1 || stall_cnt !== 1) begin n_err++; $display("FAIL br_nt_cnt: got flush=%0d stall=%0d want 1/1", flush_cnt, stall_cnt); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            mem_op = 6'h2B; mem_ready = 0;
            for (int c = 0; c < 3; c++) begin
                #2;
                n_vec++; if (outs !== O_FROZEN) begin n_err++; $display("FAIL mw_frozen r%0d c%0d: got %b want %b", rep, c, outs, O_FROZEN); end
                tick();
            end
            mem_ready = 1;
            #2;
            n_vec++; if (outs !== O_NORMAL) begin n_err++; $display("FAIL mw_release r%0d: got %b want %b", rep, outs, O_NORMAL); end
            tick();
            n_vec++; if (stall_cnt !== CNT_W'(3 * (rep + 1)) || mem_err !== 0) begin n_err++; $display("FAIL mw_cnt r%0d: got stall=%0d err=%b want %0d/0", rep, stall_cnt, mem_err, 3 * (rep + 1)); end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        mem_op = 6'h23; mem_ready = 0;
        for (int c = 0; c < 3; c++) begin
            #2;
            n_vec++; if (outs !== O_FROZEN) begin n_err++; $display("FAIL to_frozen c%0d: got %b want %b", c, outs, O_FROZEN); end
            n_vec++; if (mem_err !== 0) begin n_err++; $display("FAIL to_err_early c%0d: got %b want 0", c, mem_err); end
            tick();
        end
        #2;
        n_vec++; if (outs !== O_NORMAL) begin n_err++; $display("FAIL to_forced: got %b want %b", outs, O_NORMAL); end
        tick();
        n_vec++; if (mem_err !== 1 || stall_cnt !== 3) begin n_err++; $display("FAIL to_err: got err=%b stall=%0d want 1/3", mem_err, stall_cnt); end
        idle();
        tick();
        tick();
        n_vec++; if (mem_err !== 1) begin n_err++; $display("FAIL to_sticky: got %b want 1", mem_err); end
    endtask

    task automatic test_halt();
        do_reset();
        halt_req = 1;
        #2;
        n_vec++; if (outs !== O_NORMAL || halt_ack !== 0) begin n_err++; $display("FAIL h_advance: got %b ack=%b want %b/0", outs, halt_ack, O_NORMAL); end
        tick();
        for (int c = 0; c < 3; c++) begin
            n_vec++; if (outs !== O_FROZEN || halt_ack !== 1) begin n_err++; $display("FAIL h_held c%0d: got %b ack=%b want %b/1", c, outs, halt_ack, O_FROZEN); end
            tick();
        end
        halt_req = 0;
        #1;
        n_vec++; if (outs !== O_FROZEN || halt_ack !== 1) begin n_err++; $display("FAIL h_drop: got %b ack=%b want %b/1", outs, halt_ack, O_FROZEN); end
        tick();
        n_vec++; if (outs !== O_NORMAL || halt_ack !== 0) begin n_err++; $display("FAIL h_resume: got %b ack=%b want %b/0", outs, halt_ack, O_NORMAL); end
        n_vec++; if (stall_cnt !== 0) begin n_err++; $display("FAIL h_stall: got %0d want 0", stall_cnt); end

        do_reset();
        halt_req = 1; mem_op = 6'h2B; mem_ready = 0;
        for (int c = 0; c < 2; c++) begin
            #2;
            n_vec++; if (outs !== O_FROZEN) begin n_err++; $display("FAIL hd_frozen c%0d: got %b want %b", c, outs, O_FROZEN); end
            tick();
            n_vec++; if (halt_ack !== 0) begin n_err++; $display("FAIL hd_ack_wait c%0d: got %b want 0", c, halt_ack); end
        end
        mem_ready = 1;
        tick();
        n_vec++; if (halt_ack !== 0) begin n_err++; $display("FAIL hd_ack_release: got %b want 0", halt_ack); end
        mem_op = 0; mem_ready = 0;
        #1;
        n_vec++; if (outs !== O_NORMAL) begin n_err++; $display("FAIL hd_run: got %b want %b", outs, O_NORMAL); end
        tick();
        n_vec++; if (halt_ack !== 1 || outs !== O_FROZEN || stall_cnt !== 2) begin n_err++; $display("FAIL hd_halted: got ack=%b outs=%b stall=%0d want 1/%b/2", halt_ack, outs, stall_cnt, O_FROZEN); end
        halt_req = 0;
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        mem_op = 6'h04; mem_eq = 1;
        tick();
        mem_eq = 0; mem_op = 6'h23; mem_ready = 0;
        repeat (4) tick();
        mem_op = 6'h2B;
        repeat (2) tick();
        n_vec++; if (mem_err !== 1 || flush_cnt !== 1 || stall_cnt !== 5) begin n_err++; $display("FAIL ar_pre: got err=%b flush=%0d stall=%0d want 1/1/5", mem_err, flush_cnt, stall_cnt); end
        mem_ready = 1;
        #1;
        n_vec++; if (outs !== O_NORMAL) begin n_err++; $display("FAIL ar_pre_outs: got %b want %b", outs, O_NORMAL); end
        reset = 0;
        #1;
        n_vec++; if (outs !== O_FROZEN) begin n_err++; $display("FAIL ar_outs: got %b want %b", outs, O_FROZEN); end
        n_vec++; if (stall_cnt !== 0 || flush_cnt !== 0 || mem_err !== 0) begin n_err++; $display("FAIL ar_clear: got stall=%0d flush=%0d err=%b want 0/0/0", stall_cnt, flush_cnt, mem_err); end
        tick();
        idle();
        reset = 1;
        halt_req = 1;
        #1;
        n_vec++; if (outs !== O_NORMAL) begin n_err++; $display("FAIL ar_run: got %b want %b", outs, O_NORMAL); end
        tick();
        n_vec++; if (halt_ack !== 1) begin n_err++; $display("FAIL ar_halt_from_run: got %b want 1", halt_ack); end
        halt_req = 0;
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        set_load_use();
        repeat (17) tick();
        n_vec++; if (stall_cnt !== 4'hF) begin n_err++; $display("FAIL sat_stall: got %0d want 15", stall_cnt); end
        idle();
        mem_op = 6'h04; mem_eq = 1;
        repeat (17) tick();
        n_vec++; if (flush_cnt !== 4'hF || stall_cnt !== 4'hF) begin n_err++; $display("FAIL sat_flush: got flush=%0d stall=%0d want 15/15", flush_cnt, stall_cnt); end
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_halt();
        test_async_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
